register_file: RTL and testbench



---
 rtl/mips_pkg.sv | 24 ++
 rtl/register_file_decoder5_32.sv | 27 ++
 rtl/register_file.sv | 81 ++++++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Register-file geometry and instruction field positions shared by
//             the register file, destination-register mux and control unit.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    // Bit positions of the rt and rd fields inside an instruction word
    localparam int REG_RT_MSB = 20;
    localparam int REG_RT_LSB = 16;
    localparam int REG_RD_MSB = 15;
    localparam int REG_RD_LSB = 11;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/register_file_decoder5_32.sv
`default_nettype none
// ============================================================================
//  Module   : decoder5_32
//  Brief    : Write-address decoder; gated one-hot write enables for $1..$31.
//  Revision : 1.0  initial release
// ============================================================================
module decoder5_32
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int N_OUT  = NUM_REGS
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_OUT-1:1]  o_we
);

    // $0 has no storage, so it gets no enable line at all
    always_comb begin
        o_we = '0;
        for (int i = 1; i < N_OUT; i++) begin
            o_we[i] = i_en && (i_addr == ADDR_W'(i));
        end
    end

endmodule : decoder5_32
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Brief    : 32 x 32 MIPS GPR file, one synchronous write port, two
//             combinational read ports, $0 hardwired to zero.
//  Revision : 1.0  initial release
// ============================================================================
module register_file #(
    parameter int DATA_W   = mips_pkg::REG_DATA_W,
    parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    import mips_pkg::*;

    logic [NUM_REGS-1:1] w_we;
    logic [DATA_W-1:0]   r_regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0]   w_regs_d [1:NUM_REGS-1];

    decoder5_32 #(
        .ADDR_W (ADDR_W),
        .N_OUT  (NUM_REGS)
    ) u_wr_dec (
        .i_en   (RegWrite),
        .i_addr (WriteReg),
        .o_we   (w_we)
    );

    // Reset has priority over a concurrent write
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (reset) begin
                w_regs_d[i] = '0;
            end else if (w_we[i]) begin
                w_regs_d[i] = WriteData;
            end else begin
                w_regs_d[i] = r_regs_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            r_regs_q[i] <= w_regs_d[i];
        end
    end

    // Read muxes look only at stored state, never at the write path
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = (p == 0) ? ReadReg1 : ReadReg2;

        always_comb begin
            w_data = '0;
            if (w_addr != ADDR_W'(REG_ZERO)) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (w_addr == ADDR_W'(i)) begin
                        w_data = r_regs_q[i];
                    end
                end
            end
        end
    end

    assign ReadData1 = g_rd_port[0].w_data;
    assign ReadData2 = g_rd_port[1].w_data;

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file
//  Brief    : Self-checking bench for register_file (vector table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int total = 0;
    int bad   = 0;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        string       tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];

    // Compare the oldest expectation against what the read ports show now
    task automatic check_sb();
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: actual=0 entries required>=1");
            return;
        end
        x = sb.pop_front();
        total++;
        if (ReadData1 !== x.e1) begin
            bad++;
            $display("FAIL %s rd1: actual=%h required=%h", x.tag, ReadData1, x.e1);
        end
        total++;
        if (ReadData2 !== x.e2) begin
            bad++;
            $display("FAIL %s rd2: actual=%h required=%h", x.tag, ReadData2, x.e2);
        end
    endtask

    // Drive one cycle of inputs, sample reads before the commit edge
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] e1, input logic [31:0] e2, input string tag);
        exp_t x;
        @(negedge clk);
        reset     = rst;
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
        x.e1  = e1;
        x.e2  = e2;
        x.tag = tag;
        sb.push_back(x);
        #2;
        check_sb();
    endtask

    initial begin
        //          rst   we    wa     wd            r1     r2     e1            e2
        vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd9,  32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[5]  = '{1'b0, 1'b1, 5'd5,  32'h11,       5'd5,  5'd5,  32'h0,        32'h0};
        vecs[6]  = '{1'b0, 1'b1, 5'd5,  32'h22,       5'd5,  5'd5,  32'h11,       32'h11};
        vecs[7]  = '{1'b0, 1'b0, 5'd31, 32'h1234,     5'd5,  5'd8,  32'h22,       32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b0, 5'd31, 32'h1234,     5'd31, 5'd31, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 1'b0, 5'd31, 32'h1234,     5'd31, 5'd31, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h0,        32'h0};
        vecs[11] = '{1'b0, 1'b1, 5'd31, 32'hCAFE0000, 5'd31, 5'd5,  32'h0,        32'h22};
        vecs[12] = '{1'b1, 1'b1, 5'd31, 32'h1,        5'd31, 5'd8,  32'hCAFE0000, 32'hDEADBEEF};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd8,  32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd9,  32'h0,        32'h0};
        vecs[15] = '{1'b0, 1'b1, 5'd1,  32'hA5A5A5A5, 5'd1,  5'd1,  32'h0,        32'h0};

        reset     = 1'b1;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        @(posedge clk);

        // Post-reset sweep of every address on both ports
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0, $sformatf("reset_sweep_%0d", i));
        end

        for (int v = 0; v < 16; v++) begin
            step(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].r1, vecs[v].r2,
                 vecs[v].e1, vecs[v].e2, $sformatf("vec_%0d", v));
        end
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'hA5A5A5A5, 32'h0, "vec_15_after");

        // Fill every register with address*3; each write is visible next cycle only
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'(i * 3), 5'(i), 5'(i - 1),
                 (i == 1) ? 32'hA5A5A5A5 : 32'h0, (i == 1) ? 32'h0 : 32'((i - 1) * 3),
                 $sformatf("fill_%0d", i));
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i),
                 32'(i * 3), (i == 31) ? 32'h0 : 32'((31 - i) * 3),
                 $sformatf("readback_%0d", i));
        end

        // Reset clears the whole file, including the concurrent write
        step(1'b1, 1'b1, 5'd20, 32'h77, 5'd20, 5'd30, 32'd60, 32'd90, "reset_with_write");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd30, 32'h0, 32'h0, "after_full_reset");

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
